ps2_host_transmitter: RTL

//   Host-to-device PS/2 transmitter: the send direction of the PS/2 link whose receive side feeds

---
 rtl/ps2_host_transmitter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity,
// stop and device ack, with a per-edge watchdog and one-cycle done/error pulses.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_Clock_in,
  input  logic       PS2_Data_in,
  output logic       PS2_Clock_drive_low,
  output logic       PS2_Data_drive_low
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   prev_clk_q, prev_clk_d;
  logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [8:0]             shift_q, shift_d;
  logic                   clk_drv_q, clk_drv_d;
  logic                   dat_drv_q, dat_drv_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic sync_clk, sync_dat, fall, watched;

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dat = dat_sync_q[SYNC_STAGES-1];
  assign fall     = prev_clk_q & ~sync_clk;
  assign watched  = (state_q == S_RTS) || (state_q == S_DATA) || (state_q == S_ACK);

  assign tx_ready            = (state_q == S_IDLE);
  assign busy                = (state_q != S_IDLE);
  assign tx_done             = done_q;
  assign tx_error            = err_q;
  assign PS2_Clock_drive_low = clk_drv_q;
  assign PS2_Data_drive_low  = dat_drv_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_Clock_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_Data_in};
    prev_clk_d = sync_clk;
  end

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (tx_valid) begin
          // Parity rides in bit 8 so it shifts out right after the data.
          shift_d   = {~^tx_data, tx_data};
          inh_cnt_d = '0;
          tmo_cnt_d = '0;
          bit_cnt_d = '0;
          clk_drv_d = 1'b1;
          dat_drv_d = (INHIBIT_CYCLES == 1);
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_RTS;
        end else if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) begin
          dat_drv_d = 1'b1;
        end
      end
      S_RTS: begin
        if (fall) begin
          bit_cnt_d = 4'd1;
          dat_drv_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            // Tenth fall: release the line so the stop bit reads as 1.
            dat_drv_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            dat_drv_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          bit_cnt_d = 4'd11;
          dat_drv_d = 1'b0;
          done_d    = ~sync_dat;
          err_d     = sync_dat;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (sync_clk && sync_dat) state_d = S_IDLE;
      end
      default: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Watchdog on the device clock; a fall always wins over expiry.
    if (watched) begin
      if (fall) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt_d = '0;
        bit_cnt_d = '0;
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        err_d     = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      prev_clk_q <= 1'b1;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      prev_clk_q <= prev_clk_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
